// File: rtl/string_printer_q.sv
// string_printer_q: streams a ROM string byte by byte to uart_tx, with a one-deep request buffer and abort.
// Define PRINTER_CRLF_EN to append CR LF after every string (including empty ones).
//
// state  | meaning
// IDLE   | waiting for a buffered request
// SETUP  | latch clamped length, point ROM at byte 0
// FETCH  | one cycle of ROM read latency
// SEND   | launch a string byte to uart_tx
// WAIT   | byte in flight, waiting for tx_done
// TAIL   | launch CR or LF (PRINTER_CRLF_EN only)
// FINISH | pulse done / aborted
module string_printer_q #(
    parameter int ID_W = 2,
    parameter int MAX_LEN = 32,
    localparam int LEN_W = $clog2(MAX_LEN + 1),
    localparam int ADDR_W = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ID_W-1:0]   req_id,
    input  logic              abort,
    output logic [ID_W-1:0]   rom_id,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [LEN_W-1:0]  rom_len,
    input  logic [7:0]        rom_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        FETCH,
        SEND,
        WAIT,
        FINISH
`ifdef PRINTER_CRLF_EN
        , TAIL
`endif
    } state_t;

    state_t              state, state_n;
    logic                pend_valid, pend_valid_n;
    logic [ID_W-1:0]     pend_id, pend_id_n;
    logic [ID_W-1:0]     rom_id_n;
    logic [ADDR_W-1:0]   rom_addr_n;
    logic [ADDR_W-1:0]   idx, idx_n;
    logic [LEN_W-1:0]    len, len_n;
    logic [7:0]          tx_data_n;
    logic                tx_start_n, done_n, aborted_n;
    logic                abrt, abrt_n;
`ifdef PRINTER_CRLF_EN
    logic                in_tail, in_tail_n;
    logic                tail_lf, tail_lf_n;
`endif

    logic                accept, pop, last_byte;
    logic [LEN_W-1:0]    len_clamped;

    assign req_ready   = !pend_valid && !abort;
    assign accept      = req_valid && req_ready;
    assign pop         = (state == IDLE) && pend_valid && !abort;
    assign busy        = (state != IDLE);
    assign len_clamped = (rom_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : rom_len;
    assign last_byte   = (LEN_W'(idx) == len - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            pend_id    <= '0;
            rom_id     <= '0;
            rom_addr   <= '0;
            idx        <= '0;
            len        <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            abrt       <= 1'b0;
`ifdef PRINTER_CRLF_EN
            in_tail    <= 1'b0;
            tail_lf    <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            pend_valid <= pend_valid_n;
            pend_id    <= pend_id_n;
            rom_id     <= rom_id_n;
            rom_addr   <= rom_addr_n;
            idx        <= idx_n;
            len        <= len_n;
            tx_data    <= tx_data_n;
            tx_start   <= tx_start_n;
            done       <= done_n;
            aborted    <= aborted_n;
            abrt       <= abrt_n;
`ifdef PRINTER_CRLF_EN
            in_tail    <= in_tail_n;
            tail_lf    <= tail_lf_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        pend_valid_n = pend_valid;
        pend_id_n    = pend_id;
        rom_id_n     = rom_id;
        rom_addr_n   = rom_addr;
        idx_n        = idx;
        len_n        = len;
        tx_data_n    = tx_data;
        tx_start_n   = 1'b0;
        done_n       = 1'b0;
        aborted_n    = 1'b0;
        abrt_n       = abrt;
`ifdef PRINTER_CRLF_EN
        in_tail_n    = in_tail;
        tail_lf_n    = tail_lf;
`endif

        // abort wins over everything in the buffer; pop and accept cannot overlap since accept needs it empty
        if (abort) begin
            pend_valid_n = 1'b0;
        end else begin
            if (pop) pend_valid_n = 1'b0;
            if (accept) begin
                pend_valid_n = 1'b1;
                pend_id_n    = req_id;
            end
        end

        case (state)
            IDLE: begin
                if (pop) begin
                    rom_id_n = pend_id;
                    state_n  = SETUP;
                end
            end
            SETUP: begin
                len_n      = len_clamped;
                idx_n      = '0;
                rom_addr_n = '0;
                if (abort) begin
                    abrt_n  = 1'b1;
                    state_n = FINISH;
                end else if (len_clamped == '0) begin
`ifdef PRINTER_CRLF_EN
                    state_n = TAIL;
`else
                    state_n = FINISH;
`endif
                end else begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    abrt_n  = 1'b1;
                    state_n = FINISH;
                end else begin
                    state_n = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    abrt_n  = 1'b1;
                    state_n = FINISH;
                end else begin
                    tx_data_n  = rom_data;
                    tx_start_n = 1'b1;
                    state_n    = WAIT;
                end
            end
            WAIT: begin
                // abort is a level that may drop before tx_done, so it is remembered in abrt
                if (abort) abrt_n = 1'b1;
                if (tx_done) begin
                    if (abrt || abort) begin
                        state_n = FINISH;
`ifdef PRINTER_CRLF_EN
                    end else if (in_tail) begin
                        if (tail_lf) begin
                            state_n = FINISH;
                        end else begin
                            tail_lf_n = 1'b1;
                            state_n   = TAIL;
                        end
`endif
                    end else if (last_byte) begin
`ifdef PRINTER_CRLF_EN
                        state_n = TAIL;
`else
                        state_n = FINISH;
`endif
                    end else begin
                        idx_n      = idx + ADDR_W'(1);
                        rom_addr_n = idx + ADDR_W'(1);
                        state_n    = FETCH;
                    end
                end
            end
`ifdef PRINTER_CRLF_EN
            TAIL: begin
                if (abort) begin
                    abrt_n  = 1'b1;
                    state_n = FINISH;
                end else begin
                    tx_data_n  = tail_lf ? 8'h0A : 8'h0D;
                    tx_start_n = 1'b1;
                    in_tail_n  = 1'b1;
                    state_n    = WAIT;
                end
            end
`endif
            FINISH: begin
                done_n    = 1'b1;
                aborted_n = abrt;
                abrt_n    = 1'b0;
`ifdef PRINTER_CRLF_EN
                in_tail_n = 1'b0;
                tail_lf_n = 1'b0;
`endif
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_string_printer_q.sv
// Testbench for string_printer_q: ROM and uart_tx responders plus a queue-based model of the expected byte stream.
module tb_string_printer_q;
    localparam int ID_W = 2;
    localparam int MAX_LEN = 32;
    localparam int LEN_W = 6;
    localparam int ADDR_W = 5;
`ifdef PRINTER_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              rst_n, req_valid, req_ready, abort;
    logic [ID_W-1:0]   req_id, rom_id;
    logic [ADDR_W-1:0] rom_addr;
    logic [LEN_W-1:0]  rom_len;
    logic [7:0]        rom_data, tx_data;
    logic              tx_start, tx_done, busy, done, aborted;

    string_printer_q #(.ID_W(ID_W), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .abort(abort), .rom_id(rom_id), .rom_addr(rom_addr), .rom_len(rom_len), .rom_data(rom_data),
        .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .busy(busy), .done(done),
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    logic [7:0]       mem [4][32];
    logic [LEN_W-1:0] lens [4];
    assign rom_len = lens[rom_id];
    always @(posedge clk) rom_data <= mem[rom_id][rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;

    bq_t byte_q, exp_q;
    int  start_cnt, done_cnt, first_start_cyc, done_cyc, max_addr;
    int  done_cyc_q[$];
    logic last_aborted;

    always @(negedge clk) begin
        if (tx_start) begin
            byte_q.push_back(tx_data);
            start_cnt = start_cnt + 1;
            if (first_start_cyc < 0) first_start_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            last_aborted = aborted;
            done_cyc = cyc;
            done_cyc_q.push_back(cyc);
        end
        if (busy && int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
    end

    // uart_tx stand-in: tx_done arrives uart_dly cycles after each tx_start
    int   uart_dly = 4;
    bit   uart_busy = 1'b0;
    bit   chk_stable = 1'b1;
    int   unstable_cnt = 0;
    int   overlap_cnt = 0;
    logic [7:0] held;
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tx_start && rst_n) begin
                uart_busy = 1'b1;
                held = tx_data;
                for (int k = 0; k < uart_dly; k++) begin
                    @(posedge clk); #1;
                    if (chk_stable && rst_n && tx_data !== held) unstable_cnt++;
                    if (tx_start) overlap_cnt++;
                end
                tx_done = 1'b1;
                @(posedge clk); #1;
                tx_done = 1'b0;
                uart_busy = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic string fmt_q(input bq_t q);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        byte_q.delete();
        exp_q.delete();
        done_cyc_q.delete();
        start_cnt = 0;
        done_cnt = 0;
        first_start_cyc = -1;
        done_cyc = -1;
        max_addr = -1;
        last_aborted = 1'b0;
        unstable_cnt = 0;
        overlap_cnt = 0;
    endtask

    task automatic expect_string(input int id, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mem[id][i]);
        if (CRLF) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic fill_random(input int id);
        for (int i = 0; i < 32; i++) mem[id][i] = 8'($urandom);
    endtask

    task automatic send_req(input int id, output int acc);
        req_id = ID_W'(id);
        req_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk); #1;
                acc = cyc;
                break;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL req_accept id=%0d got timeout required acceptance", id);
        end
    endtask

    task automatic wait_idle();
        int stable = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (!busy && !uart_busy) stable++;
            else stable = 0;
            if (stable >= 3) break;
        end
        checks++;
        if (stable < 3) begin
            errors++;
            $display("FAIL wait_idle got busy=%0b required idle", busy);
        end
        tick(1);
    endtask

    task automatic wait_starts(input int n);
        for (int k = 0; k < 500; k++) begin
            if (start_cnt >= n) break;
            @(negedge clk);
        end
        checks++;
        if (start_cnt < n) begin
            errors++;
            $display("FAIL wait_starts got %0d required %0d", start_cnt, n);
        end
        tick(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start got %b required 0", tx_start); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b required 0", done); end
        checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL rst_aborted got %b required 0", aborted); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h required 00", tx_data); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL rst_rom_addr got %h required 0", rom_addr); end
        checks++; if (rom_id !== '0) begin errors++; $display("FAIL rst_rom_id got %h required 0", rom_id); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b required 1", req_ready); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_ok_string();
        int acc;
        clear_mon();
        lens[1] = 6'd2;
        mem[1][0] = 8'h4F;
        mem[1][1] = 8'h4B;
        uart_dly = 10;
        exp_q.push_back(8'h4F);
        exp_q.push_back(8'h4B);
        if (CRLF) begin exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); end
        send_req(1, acc);
        wait_idle();
        checks++; if (fmt_q(byte_q) != fmt_q(exp_q)) begin errors++; $display("FAIL ok_bytes got %s required %s", fmt_q(byte_q), fmt_q(exp_q)); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ok_done_cnt got %0d required 1", done_cnt); end
        checks++; if (last_aborted !== 1'b0) begin errors++; $display("FAIL ok_aborted got %b required 0", last_aborted); end
        checks++; if (first_start_cyc - acc != 4) begin errors++; $display("FAIL ok_latency got %0d required 4", first_start_cyc - acc); end
        checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL ok_overlap got %0d required 0", overlap_cnt); end
        checks++; if (unstable_cnt != 0) begin errors++; $display("FAIL ok_tx_data_stable got %0d required 0", unstable_cnt); end
    endtask

    task automatic test_zero_len();
        int acc;
        clear_mon();
        lens[3] = 6'd0;
        uart_dly = 3;
        send_req(3, acc);
        wait_idle();
        checks++; if (start_cnt != (CRLF ? 2 : 0)) begin errors++; $display("FAIL zero_starts got %0d required %0d", start_cnt, CRLF ? 2 : 0); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_cnt got %0d required 1", done_cnt); end
`ifndef PRINTER_CRLF_EN
        checks++; if (done_cyc - acc != 3) begin errors++; $display("FAIL zero_done_latency got %0d required 3", done_cyc - acc); end
`endif
    endtask

    task automatic test_random_strings();
        int acc, id, n;
        for (int it = 0; it < 8; it++) begin
            clear_mon();
            id = int'($urandom_range(0, 3));
            n = int'($urandom_range(0, 40));
            lens[id] = LEN_W'(n);
            fill_random(id);
            uart_dly = int'($urandom_range(1, 6));
            expect_string(id, (n > MAX_LEN) ? MAX_LEN : n);
            send_req(id, acc);
            wait_idle();
            checks++; if (fmt_q(byte_q) != fmt_q(exp_q)) begin errors++; $display("FAIL rand_bytes it=%0d got %s required %s", it, fmt_q(byte_q), fmt_q(exp_q)); end
            checks++; if (done_cnt != 1 || last_aborted !== 1'b0) begin errors++; $display("FAIL rand_done it=%0d got cnt=%0d ab=%b required cnt=1 ab=0", it, done_cnt, last_aborted); end
        end
        checks++; if (overlap_cnt != 0 || unstable_cnt != 0) begin errors++; $display("FAIL rand_handshake got overlap=%0d unstable=%0d required 0", overlap_cnt, unstable_cnt); end
    endtask

    task automatic test_back_to_back();
        int a1, a2, a3;
        clear_mon();
        lens[1] = 6'd3; fill_random(1);
        lens[2] = 6'd4; fill_random(2);
        lens[3] = 6'd2; fill_random(3);
        uart_dly = 10;
        expect_string(1, 3);
        expect_string(2, 4);
        expect_string(3, 2);
        send_req(1, a1);
        wait_starts(1);
        send_req(2, a2);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop got %b required 0", req_ready); end
        send_req(3, a3);
        checks++; if (done_cyc_q.size() < 1 || a3 <= done_cyc_q[0]) begin errors++; $display("FAIL b2b_third_held got acc=%0d dones=%0d required after first done", a3, done_cyc_q.size()); end
        wait_idle();
        checks++; if (fmt_q(byte_q) != fmt_q(exp_q)) begin errors++; $display("FAIL b2b_bytes got %s required %s", fmt_q(byte_q), fmt_q(exp_q)); end
        checks++; if (done_cnt != 3) begin errors++; $display("FAIL b2b_done_cnt got %0d required 3", done_cnt); end
    endtask

    task automatic test_abort_wait();
        int a, a0;
        clear_mon();
        lens[2] = 6'd5; fill_random(2);
        lens[0] = 6'd3; fill_random(0);
        uart_dly = 10;
        exp_q.push_back(mem[2][0]);
        exp_q.push_back(mem[2][1]);
        send_req(2, a);
        wait_starts(2);
        send_req(0, a0);
        tick(2);
        abort = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b required 0", req_ready); end
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle();
        tick(20);
        checks++; if (fmt_q(byte_q) != fmt_q(exp_q)) begin errors++; $display("FAIL abort_bytes got %s required %s", fmt_q(byte_q), fmt_q(exp_q)); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL abort_done_cnt got %0d required 1", done_cnt); end
        checks++; if (last_aborted !== 1'b1) begin errors++; $display("FAIL abort_flag got %b required 1", last_aborted); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_flush got busy=%b required 0", busy); end
    endtask

    task automatic test_clamp();
        int acc;
        clear_mon();
        lens[0] = 6'd40;
        fill_random(0);
        uart_dly = 1;
        expect_string(0, MAX_LEN);
        send_req(0, acc);
        wait_idle();
        checks++; if (fmt_q(byte_q) != fmt_q(exp_q)) begin errors++; $display("FAIL clamp_bytes got %s required %s", fmt_q(byte_q), fmt_q(exp_q)); end
        checks++; if (max_addr != MAX_LEN - 1) begin errors++; $display("FAIL clamp_max_addr got %0d required %0d", max_addr, MAX_LEN - 1); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL clamp_done_cnt got %0d required 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int acc;
        clear_mon();
        lens[1] = 6'd5; fill_random(1);
        uart_dly = 10;
        send_req(1, acc);
        wait_starts(1);
        tick(3);
        chk_stable = 1'b0;
        rst_n = 1'b0;
        tick(1);
        checks++; if ({tx_start, done, aborted, busy, tx_data, rom_addr, rom_id} !== '0) begin errors++;
            $display("FAIL midrst_outputs got st=%b dn=%b ab=%b bz=%b d=%h a=%h id=%h required all 0", tx_start, done, aborted, busy, tx_data, rom_addr, rom_id); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b required 1", req_ready); end
        rst_n = 1'b1;
        clear_mon();
        wait_idle();
        tick(5);
        checks++; if (start_cnt != 0 || done_cnt != 0) begin errors++; $display("FAIL midrst_stray got starts=%0d dones=%0d required 0", start_cnt, done_cnt); end
        chk_stable = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_id = '0;
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lens[i] = '0;
            for (int j = 0; j < 32; j++) mem[i][j] = 8'h00;
        end
        clear_mon();
        test_reset();
        test_ok_string();
        test_zero_len();
        test_random_strings();
        test_back_to_back();
        test_abort_wait();
        test_clamp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
